// File: rtl/spi_master_core.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) byte shift engine that holds CS low across bursts.
// Define SPI_MASTER_LOOPBACK_EN to build the internal MOSI->sampler loopback selected by lb.
module spi_master_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_last,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             lb,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic             spi_cs_n,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  typedef enum logic [2:0] {IDLE, LEAD, SCK_HI, SCK_LO, WAIT, TRAIL, GAP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       txShift_q, txShift_d;
  logic [7:0]       rxShift_q, rxShift_d;
  logic [7:0]       rspData_q, rspData_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             last_q, last_d;
  logic             rspValid_q, rspValid_d;
  logic             live_q;
  logic             accept, tick, sampleBit, driveMosi;

  assign tick      = (divCnt_q == div_q);
  assign cmd_ready = live_q && ((state_q == IDLE) || (state_q == WAIT));
  assign accept    = cmd_valid && cmd_ready;
  assign driveMosi = (state_q != IDLE) && (state_q != GAP);

  assign busy      = (state_q != IDLE);
  assign spi_cs_n  = (state_q == IDLE) || (state_q == GAP);
  assign spi_sck   = (state_q == SCK_HI);
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_q <= 1'b0;
    end else if (accept) begin
      lb_q <= lb;
    end
  end

  assign sampleBit = lb_q ? txShift_q[7] : spi_miso;
  assign spi_mosi  = (driveMosi && !lb_q) ? txShift_q[7] : 1'b0;
`else
  logic unusedLb;
  assign unusedLb  = lb;
  assign sampleBit = spi_miso;
  assign spi_mosi  = driveMosi ? txShift_q[7] : 1'b0;
`endif

  // cmd_ready must stay low while reset is held, so it is gated by a flag set one cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      rspData_q  <= '0;
      bitCnt_q   <= '0;
      divCnt_q   <= '0;
      div_q      <= '0;
      last_q     <= 1'b0;
      rspValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txShift_q  <= txShift_d;
      rxShift_q  <= rxShift_d;
      rspData_q  <= rspData_d;
      bitCnt_q   <= bitCnt_d;
      divCnt_q   <= divCnt_d;
      div_q      <= div_d;
      last_q     <= last_d;
      rspValid_q <= rspValid_d;
    end
  end

  // MISO is captured on the cycle edge that raises SCK, i.e. whenever SCK_HI is entered
  always_comb begin
    state_d    = state_q;
    txShift_d  = txShift_q;
    rxShift_d  = rxShift_q;
    rspData_d  = rspData_q;
    bitCnt_d   = bitCnt_q;
    div_d      = div_q;
    last_d     = last_q;
    rspValid_d = 1'b0;
    if ((state_q == IDLE) || (state_q == WAIT) || tick) begin
      divCnt_d = '0;
    end else begin
      divCnt_d = divCnt_q + 1'b1;
    end
    case (state_q)
      IDLE, WAIT: begin
        if (accept) begin
          txShift_d = cmd_data;
          last_d    = cmd_last;
          div_d     = clk_div;
          bitCnt_d  = '0;
          divCnt_d  = '0;
          state_d   = LEAD;
        end
      end
      LEAD, SCK_LO: begin
        if (tick) begin
          rxShift_d = {rxShift_q[6:0], sampleBit};
          state_d   = SCK_HI;
        end
      end
      SCK_HI: begin
        if (tick) begin
          if (bitCnt_q == 3'd7) begin
            rspValid_d = 1'b1;
            rspData_d  = rxShift_q;
            state_d    = last_q ? TRAIL : WAIT;
          end else begin
            txShift_d = {txShift_q[6:0], 1'b0};
            bitCnt_d  = bitCnt_q + 3'd1;
            state_d   = SCK_LO;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed self-checking bench for spi_master_core with a mode-0 SPI slave model on MISO.
// Loopback expectations follow SPI_MASTER_LOOPBACK_EN when the bench is built with it.
module tb_spi_master_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_last = 1'b0;
  logic [7:0] clk_div = 8'h00;
  logic       lb = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  logic [7:0] misoByte = 8'h00;
  logic [2:0] bitIdx = 3'd0;
  int         cyc = 0;

  int         checks = 0;
  int         failures = 0;

  int         rspCount, rspCyc, csRises, csRiseCyc, readyRiseCyc, sckRises, mosiOnes;
  int         hiMin, hiMax, loMin, loMax, hiCount, loCount, run;
  logic [7:0] lastRsp, mosiBits;
  logic       hiSeen, prevCs, prevSck, prevReady;
  int         t0, t1, t2;

  spi_master_core #(.DIV_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_last  (cmd_last),
    .clk_div   (clk_div),
    .lb        (lb),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: presents the next MISO bit after each SCK fall, restarting whenever CS rises
  always @(negedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) bitIdx = 3'd0;
    else          bitIdx = bitIdx + 3'd1;
  end
  assign spi_miso = misoByte[3'd7 - bitIdx];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearStats();
    rspCount = 0; csRises = 0; sckRises = 0; mosiOnes = 0; mosiBits = 8'h00; lastRsp = 8'h00;
    rspCyc = -1; csRiseCyc = -1; readyRiseCyc = -1;
    hiMin = 1000; hiMax = 0; loMin = 1000; loMax = 0; hiCount = 0; loCount = 0; hiSeen = 1'b0;
  endtask

  // Advance to the next falling clock edge and fold the observed pins into the statistics
  task automatic step();
    @(negedge clk);
    if (rsp_valid) begin
      rspCount++; rspCyc = cyc; lastRsp = rsp_data;
    end
    if (spi_cs_n && !prevCs) begin
      csRises++; csRiseCyc = cyc;
    end
    if (cmd_ready && !prevReady) readyRiseCyc = cyc;
    if (spi_mosi) mosiOnes++;
    if (spi_sck && !prevSck) begin
      sckRises++;
      mosiBits = {mosiBits[6:0], spi_mosi};
      if (hiSeen) begin
        loCount++;
        if (run < loMin) loMin = run;
        if (run > loMax) loMax = run;
      end
    end
    if (!spi_sck && prevSck) begin
      hiCount++; hiSeen = 1'b1;
      if (run < hiMin) hiMin = run;
      if (run > hiMax) hiMax = run;
    end
    if (spi_sck == prevSck) run++;
    else                    run = 1;
    prevCs = spi_cs_n; prevSck = spi_sck; prevReady = cmd_ready;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic last, input logic [7:0] div, output int acceptCyc);
    int n;
    cmd_data = data; cmd_last = last; clk_div = div; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin
      step();
      n++;
    end
    checkOutput("accept_wait", cmd_ready, 1'b1);
    acceptCyc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    checkOutput("idle_wait", busy, 1'b0);
    step();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    prevCs = 1'b1; prevSck = 1'b0; prevReady = 1'b0; run = 0;
    clearStats();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", spi_cs_n, 1'b1);
    checkOutput("rst_sck", spi_sck, 1'b0);
    checkOutput("rst_mosi", spi_mosi, 1'b0);
    checkOutput("rst_ready", cmd_ready, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_data", rsp_data, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    checkOutput("idle_ready", cmd_ready, 1'b1);

    $display("[TB] single byte 0xA5, clk_div=0");
    clearStats();
    misoByte = 8'h3C;
    applyStimulus(8'hA5, 1'b1, 8'd0, t0);
    checkOutput("single_cs_low", spi_cs_n, 1'b0);
    checkOutput("single_mosi_bit7", spi_mosi, 1'b1);
    waitIdle();
    checkOutput("single_mosi_bits", mosiBits, 8'hA5);
    checkOutput("single_sck_rises", sckRises, 8);
    checkOutput("single_rsp_count", rspCount, 1);
    checkOutput("single_rsp_data", lastRsp, 8'h3C);
    checkOutput("single_rsp_time", rspCyc - t0, 17);
    checkOutput("single_cs_high_time", csRiseCyc - t0, 18);
    checkOutput("single_ready_time", readyRiseCyc - t0, 19);

    $display("[TB] burst 0x03 0x00 0x10, clk_div=3");
    clearStats();
    misoByte = 8'hC3;
    applyStimulus(8'h03, 1'b0, 8'd3, t0);
    applyStimulus(8'h00, 1'b0, 8'd3, t1);
    applyStimulus(8'h10, 1'b1, 8'd3, t2);
    waitIdle();
    checkOutput("burst_gap1", t1 - t0, 65);
    checkOutput("burst_gap2", t2 - t1, 65);
    checkOutput("burst_rsp_count", rspCount, 3);
    checkOutput("burst_sck_rises", sckRises, 24);
    checkOutput("burst_cs_rises", csRises, 1);
    checkOutput("burst_cs_high_time", csRiseCyc - t2, 69);
    checkOutput("burst_rsp_data", lastRsp, 8'hC3);
    checkOutput("burst_last_mosi", mosiBits, 8'h10);

    $display("[TB] clk_div=2 latched, changed to 7 mid-byte");
    clearStats();
    misoByte = 8'h6B;
    applyStimulus(8'hE7, 1'b1, 8'd2, t0);
    repeat (10) step();
    clk_div = 8'd7;
    waitIdle();
    checkOutput("div_hi_min", hiMin, 3);
    checkOutput("div_hi_max", hiMax, 3);
    checkOutput("div_lo_min", loMin, 3);
    checkOutput("div_lo_max", loMax, 3);
    checkOutput("div_hi_count", hiCount, 8);
    checkOutput("div_lo_count", loCount, 7);
    checkOutput("div_ready_time", readyRiseCyc - t0, 55);
    checkOutput("div_rsp_data", lastRsp, 8'h6B);

    $display("[TB] reset at 4th SCK high");
    clearStats();
    misoByte = 8'h55;
    applyStimulus(8'h96, 1'b1, 8'd1, t0);
    while (sckRises < 4 && busy) step();
    checkOutput("rstmid_mosi_before", spi_mosi, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_cs_n", spi_cs_n, 1'b1);
    checkOutput("rstmid_sck", spi_sck, 1'b0);
    checkOutput("rstmid_mosi", spi_mosi, 1'b0);
    checkOutput("rstmid_busy", busy, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    checkOutput("rstmid_no_rsp", rspCount, 0);
    clearStats();
    misoByte = 8'h81;
    applyStimulus(8'h3C, 1'b1, 8'd1, t0);
    waitIdle();
    checkOutput("rstmid_next_mosi", mosiBits, 8'h3C);
    checkOutput("rstmid_next_rsp", lastRsp, 8'h81);
    checkOutput("rstmid_next_count", rspCount, 1);
    checkOutput("rstmid_next_time", rspCyc - t0, 33);

    $display("[TB] loopback request with MISO tied high");
    clearStats();
    misoByte = 8'hFF;
    lb = 1'b1;
    applyStimulus(8'h5A, 1'b1, 8'd0, t0);
    waitIdle();
    lb = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    checkOutput("lb_rsp_data", lastRsp, 8'h5A);
    checkOutput("lb_mosi_ones", mosiOnes, 0);
`else
    checkOutput("lb_rsp_data", lastRsp, 8'hFF);
    checkOutput("lb_mosi_bits", mosiBits, 8'h5A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
# spi_master_core

Byte-level SPI master shift engine (mode 0: CPOL=0, CPHA=0, MSB first) that sits downstream of the SPI register window and drives the SPI Flash pins. It accepts one byte per command over a valid/ready handshake and generates SCK, MOSI and chip select. It holds CS low across multi-byte transfers until a command marked `cmd_last`, and returns each received MISO byte as a one-cycle response pulse.

## Interface
- `DIV_W`, default 8: width of the clock-divider value; SCK half-period = `clk_div`+1 clk cycles.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command byte offered
- `cmd_ready`  out  1  engine accepts a command this cycle
- `cmd_data`  in  8  byte to transmit
- `cmd_last`  in  1  deassert CS after this byte
- `clk_div`  in  DIV_W  divider value, latched on each command acceptance
- `lb`  in  1  internal loopback request (see Configuration)
- `rsp_valid`  out  1  one-cycle pulse: received byte valid
- `rsp_data`  out  8  received byte, held until the next `rsp_valid`
- `busy`  out  1  high whenever state != IDLE
- `spi_cs_n`  out  1  chip select, active-low
- `spi_sck`  out  1  serial clock
- `spi_mosi`  out  1  master out
- `spi_miso`  in  1  master in, used unsynchronised (flash timing is SCK-relative)

## Operation
- States: IDLE, LEAD, SCK_HI, SCK_LO, WAIT, TRAIL, GAP.
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `cmd_ready`=0 during reset and 1 in IDLE afterwards, `rsp_valid`=0, `rsp_data`=0, `busy`=0, all counters 0.
- Accept = `cmd_valid` && `cmd_ready`. `cmd_ready`=1 only in IDLE and WAIT.
- On accept:
  - Load tx shift register with `cmd_data`, latch `cmd_last` and `clk_div`.
  - Clear the bit counter (3 bits) and the divider counter.
  - Go to LEAD.
- Divider counter counts 0..`clk_div_q`. A tick occurs at `clk_div_q`, and the counter wraps to 0. Every state except IDLE/WAIT advances only on a tick.
- LEAD: CS low, SCK 0, MOSI = tx[7]. On tick, go to SCK_HI.
- SCK_HI: SCK 1. The rising edge samples MISO into the rx shift register on entry. On tick:
  - If bit_cnt = 7, go to the byte-done step.
  - Otherwise go to SCK_LO, shift tx left, drive MOSI with the new tx[7], and increment bit_cnt.
- Byte done (8th falling edge): SCK 0, `rsp_data` = rx byte, `rsp_valid` pulses for 1 cycle. Then go to TRAIL if `cmd_last`, else WAIT.
- SCK_LO: SCK 0. On tick, go to SCK_HI.
- WAIT: CS held low, SCK 0, MOSI holds the last bit. Stays until the next accept, which goes to LEAD (CS stays low, no CS glitch).
- TRAIL: CS low, SCK 0 for one half-period, then CS goes high and the state goes to GAP.
- GAP: CS high, `cmd_ready`=0 for one half-period (minimum CS-high time), then IDLE.
- No response backpressure: the consumer must capture `rsp_data` on `rsp_valid`.
- `clk_div` changes while busy have no effect until the next accept.

## Timing
- H = `clk_div_q`+1 cycles.
- Accept at cycle T gives `spi_cs_n`=0 and MOSI=bit7 at T+1.
- First SCK rise at T+1+H. Eight SCK highs of H cycles each, separated by seven lows of H cycles.
- `rsp_valid` at T+1+16H. With `clk_div`=0, that is T+17.
- Last byte: CS high at `rsp_valid`+H. `cmd_ready` returns at `rsp_valid`+2H.
- Back-to-back: an accept in the same cycle WAIT is entered restarts LEAD with no extra idle cycle.
- `clk_div` = all-ones gives H = 2^DIV_W cycles. The counter must not overflow (width DIV_W).
- Async reset mid-byte: outputs return to reset values immediately. The partial byte is discarded and no `rsp_valid` is issued.

## Configuration
- `SPI_MASTER_LOOPBACK_EN` defined: while `lb`=1 (sampled at accept), the sampler uses internal MOSI instead of `spi_miso`, and `spi_mosi` is forced 0. `rsp_data` then equals `cmd_data`.
- Not defined: `lb` is ignored, and no loopback logic is synthesised.

## Test plan
- Single byte 0xA5, `cmd_last`=1, `clk_div`=0, MISO model returns 0x3C:
  - MOSI rising-edge samples = 1,0,1,0,0,1,0,1.
  - `rsp_data`=0x3C at T+17; CS high at T+18; `cmd_ready` at T+19.
- Three-byte burst 0x03,0x00,0x10 (last on the third), `clk_div`=3: CS stays continuously low across all bytes, three `rsp_valid` pulses, 24 SCK rises total.
- `clk_div`=2 latched, then changed to 7 mid-byte: every SCK high and low phase measures exactly 3 cycles.
- Reset asserted at the 4th SCK high: CS=1, SCK=0, MOSI=0 at once, no `rsp_valid`. The next byte transfers correctly.
- With `SPI_MASTER_LOOPBACK_EN` and `lb`=1, send 0x5A with MISO tied 1: `rsp_data`=0x5A and `spi_mosi` stays 0. Without the macro, `rsp_data`=0xFF.
